// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready handshake bundle between two pipeline stages
interface pipe_skid_reg_if #(
    parameter int DATA_W = 64
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic stage register with 2-entry skid buffer; optional counters via PIPE_SKID_PERF_EN
module pipe_skid_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PIPE_SKID_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    pipe_skid_reg_if.slave    bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] main_data, main_nx;
    logic [DATA_W-1:0] skid_data, skid_nx;
    logic              main_valid, skid_valid, acc, emit;

    assign main_valid    = state != EMPTY;
    assign skid_valid    = state == FULL;
    assign bus.in_ready  = ~skid_valid & ~rst;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign acc           = bus.in_valid & bus.in_ready;
    assign emit          = main_valid & bus.out_ready;

    // state register and payload storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= FLUSH_VAL;
            skid_data <= FLUSH_VAL;
        end else begin
            state     <= state_nx;
            main_data <= main_nx;
            skid_data <= skid_nx;
        end
    end

    // next state: flush wins, otherwise the skid FSM moves on acc/emit
    always_comb begin
        state_nx = state;
        main_nx  = main_data;
        skid_nx  = skid_data;
        if (bus.flush) begin
            state_nx = EMPTY;
            main_nx  = FLUSH_VAL;
            skid_nx  = FLUSH_VAL;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state_nx = ONE;
                    main_nx  = bus.in_data;
                end
                ONE: if (acc && emit) begin
                    main_nx  = bus.in_data;
                end else if (acc) begin
                    state_nx = FULL;
                    skid_nx  = bus.in_data;
                end else if (emit) begin
                    state_nx = EMPTY;
                    main_nx  = FLUSH_VAL;
                end
                FULL: if (emit) begin
                    state_nx = ONE;
                    main_nx  = skid_data;
                    skid_nx  = FLUSH_VAL;
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = FLUSH_VAL;
                    skid_nx  = FLUSH_VAL;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W:0] flush_sum;

    assign flush_sum = {1'b0, flush_cnt} + {{CNT_W{1'b0}}, main_valid} + {{CNT_W{1'b0}}, skid_valid};

    // saturating stall and discarded-entry counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !bus.out_ready && !bus.flush && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (bus.flush)
                flush_cnt <= flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
        end
    end
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed checks of pipe_skid_reg handshake, flush and counters
module tb_pipe_skid_reg;
    localparam int             DW = 16;
    localparam logic [DW-1:0]  FV = 16'hBEEF;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pipe_skid_reg_if #(.DATA_W(DW)) bus ();

`ifdef PIPE_SKID_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_SKID_PERF_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hA;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, FV);
            chk("rst_in_ready", bus.in_ready, 0);
        end
`ifdef PIPE_SKID_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
`endif
        rst = 1'b0;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        step();
        chk("first_valid", bus.out_valid, 1);
        chk("first_data", bus.out_data, 16'hA);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("first_drain", bus.out_valid, 0);

        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = DW'(i);
            step();
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_data", bus.out_data, i);
            chk("stream_in_ready", bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_end_valid", bus.out_valid, 0);
        chk("stream_end_data", bus.out_data, FV);

        bus.in_valid = 1'b1;
        bus.in_data = 16'h1;
        step();
        chk("bp_c1_data", bus.out_data, 16'h1);
        bus.out_ready = 1'b0;
        bus.in_data = 16'h2;
        step();
        chk("bp_full_ready", bus.in_ready, 0);
        chk("bp_full_data", bus.out_data, 16'h1);
        bus.in_data = 16'h3;
        step();
        chk("bp_hold_ready", bus.in_ready, 0);
        chk("bp_hold_data", bus.out_data, 16'h1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_out2", bus.out_data, 16'h2);
        chk("bp_ready_back", bus.in_ready, 1);
        step();
        chk("bp_out3", bus.out_data, 16'h3);
        chk("bp_out3_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_empty", bus.out_valid, 0);
`ifdef PIPE_SKID_PERF_EN
        chk("bp_stall_cnt", stall_cnt, 2);
`endif

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'h5;
        step();
        bus.in_data = 16'h6;
        step();
        chk("fl_full_ready", bus.in_ready, 0);
        chk("fl_full_data", bus.out_data, 16'h5);
        bus.flush = 1'b1;
        bus.in_data = 16'h7;
        step();
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_data", bus.out_data, FV);
        chk("fl_in_ready", bus.in_ready, 1);
`ifdef PIPE_SKID_PERF_EN
        chk("fl_flush_cnt", flush_cnt, 2);
        chk("fl_stall_cnt", stall_cnt, 3);
`endif
        step();
        chk("fl2_valid", bus.out_valid, 0);
        chk("fl2_data", bus.out_data, FV);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("fl_no7_valid", bus.out_valid, 0);
        chk("fl_no7_data", bus.out_data, FV);
`ifdef PIPE_SKID_PERF_EN
        chk("fl2_flush_cnt", flush_cnt, 2);
`endif

        bus.in_valid = 1'b1;
        bus.in_data = 16'hD;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;
        bus.flush = 1'b1;
        step();
        chk("rf_valid", bus.out_valid, 0);
        chk("rf_data", bus.out_data, FV);
        chk("rf_in_ready", bus.in_ready, 0);
`ifdef PIPE_SKID_PERF_EN
        chk("rf_flush_cnt", flush_cnt, 0);
`endif
        rst = 1'b0;
        bus.flush = 1'b0;

        bus.in_data = 16'h9;
        bus.out_ready = 1'b1;
        step();
        chk("dr_data", bus.out_data, 16'h9);
        bus.in_valid = 1'b0;
        step();
        chk("dr_valid", bus.out_valid, 0);
        chk("dr_data_fv", bus.out_data, FV);

        bus.in_valid = 1'b1;
        bus.in_data = 16'hC;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        repeat (20) step();
        chk("sat_data", bus.out_data, 16'hC);
        chk("sat_valid", bus.out_valid, 1);
`ifdef PIPE_SKID_PERF_EN
        chk("sat_stall_cnt", stall_cnt, 4'hF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
